// File: rtl/fetch_stage_ctrl_if.sv
// Front-end bundle between fetch_stage_ctrl and the rest of the pipeline.
// Optional counter outputs exist only under FETCH_PERF_COUNTERS_EN.
interface fetch_stage_ctrl_if #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 16
);
  logic                   IF_stall;
  logic                   IF_branchTaken;
  logic [PC_WIDTH-1:0]    IF_branchTarget;
  logic                   IF_memBusy;
  logic [INSTR_WIDTH-1:0] IF_imemData;
  logic [PC_WIDTH-1:0]    IF_imemAddr;
  logic [INSTR_WIDTH-1:0] IF_instruction;
  logic [PC_WIDTH-1:0]    IF_pcPlus1;
  logic                   IF_valid;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [15:0]            IF_stallCount;
  logic [15:0]            IF_flushCount;
  logic [15:0]            IF_starveCount;
`endif

  // Pipeline/memory side: drives hazards and read data, observes IF/ID.
  modport master (
    output IF_stall, IF_branchTaken, IF_branchTarget, IF_memBusy, IF_imemData,
    input  IF_imemAddr, IF_instruction, IF_pcPlus1, IF_valid
`ifdef FETCH_PERF_COUNTERS_EN
    , input IF_stallCount, IF_flushCount, IF_starveCount
`endif
  );

  // Fetch stage side.
  modport slave (
    input  IF_stall, IF_branchTaken, IF_branchTarget, IF_memBusy, IF_imemData,
    output IF_imemAddr, IF_instruction, IF_pcPlus1, IF_valid
`ifdef FETCH_PERF_COUNTERS_EN
    , output IF_stallCount, IF_flushCount, IF_starveCount
`endif
  );
endinterface

// File: rtl/fetch_stage_ctrl.sv
// PC + IF/ID register owner; optional FETCH_PERF_COUNTERS_EN adds hazard counters.
// Latency: address in cycle N, instruction at IF/ID outputs in cycle N+1.
// Backpressure: stall holds PC and IF/ID, memBusy holds PC and inserts one bubble per cycle.
module fetch_stage_ctrl #(
  parameter int                     PC_WIDTH    = 16,
  parameter int                     INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(16'h0800)
) (
  input  logic             clk,
  input  logic             rst,
  fetch_stage_ctrl_if.slave bus
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD, STARVE} state_t;

  state_t                 state;
  logic [PC_WIDTH-1:0]    pc;
  logic [INSTR_WIDTH-1:0] instr;
  logic [PC_WIDTH-1:0]    pc_plus1;
  logic                   valid;

  // Fetch address is the PC register alone; the branch target only lands next cycle.
  assign bus.IF_imemAddr    = pc;
  assign bus.IF_instruction = instr;
  assign bus.IF_pcPlus1     = pc_plus1;
  assign bus.IF_valid       = valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      instr    <= NOP_INSTR;
      pc_plus1 <= '0;
      valid    <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        default: begin
          if (bus.IF_branchTaken) begin
            pc    <= bus.IF_branchTarget;
            instr <= NOP_INSTR;
            valid <= 1'b0;
            state <= RUN;
          end else if (bus.IF_stall) begin
            state <= HOLD;
          end else if (bus.IF_memBusy) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
            state <= STARVE;
          end else begin
            instr    <= bus.IF_imemData;
            pc_plus1 <= pc + PC_WIDTH'(1);
            valid    <= 1'b1;
            pc       <= pc + PC_WIDTH'(1);
            state    <= RUN;
          end
        end
      endcase
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [15:0] starve_cnt;

  assign bus.IF_stallCount  = stall_cnt;
  assign bus.IF_flushCount  = flush_cnt;
  assign bus.IF_starveCount = starve_cnt;

  // Counters follow the same priority as the action above and saturate at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      starve_cnt <= '0;
    end else if (state != BOOT) begin
      if (bus.IF_branchTaken) begin
        if (flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
      end else if (bus.IF_stall) begin
        if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      end else if (bus.IF_memBusy) begin
        if (starve_cnt != 16'hFFFF) starve_cnt <= starve_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl; memory model returns addr + 16'h1000.
module tb_fetch_stage_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fetch_stage_ctrl_if #(.PC_WIDTH(16), .INSTR_WIDTH(16)) bus ();

  assign bus.IF_imemData = bus.IF_imemAddr + 16'h1000;

  fetch_stage_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [15:0] addr,
                            input logic [15:0] ins, input logic [15:0] pp1, input logic vld);
    check({tag, ".addr"},  {16'h0, bus.IF_imemAddr},    {16'h0, addr});
    check({tag, ".instr"}, {16'h0, bus.IF_instruction}, {16'h0, ins});
    check({tag, ".pcp1"},  {16'h0, bus.IF_pcPlus1},     {16'h0, pp1});
    check({tag, ".valid"}, {31'h0, bus.IF_valid},       {31'h0, vld});
  endtask

  initial begin
    bus.IF_stall        = 1'b0;
    bus.IF_branchTaken  = 1'b0;
    bus.IF_branchTarget = 16'h0000;
    bus.IF_memBusy      = 1'b0;

    // Reset for two cycles
    step();
    step();
    check_ifid("reset", 16'h0000, 16'h0800, 16'h0000, 1'b0);

    // BOOT cycle ignores inputs, even a branch
    rst = 1'b1;
    bus.IF_branchTaken  = 1'b1;
    bus.IF_branchTarget = 16'h0123;
    step();
    bus.IF_branchTaken = 1'b0;
    check_ifid("boot", 16'h0000, 16'h0800, 16'h0000, 1'b0);

    // Straight-line fetch: mem[0..4]
    for (int a = 0; a < 5; a++) begin
      step();
      check_ifid($sformatf("seq%0d", a), 16'(a + 1), 16'(16'h1000 + a), 16'(a + 1), 1'b1);
    end

    // Load-use stall at PC=0005 for two cycles
    bus.IF_stall = 1'b1;
    step();
    check_ifid("stall1", 16'h0005, 16'h1004, 16'h0005, 1'b1);
    step();
    check_ifid("stall2", 16'h0005, 16'h1004, 16'h0005, 1'b1);
    bus.IF_stall = 1'b0;
    step();
    check_ifid("unstall", 16'h0006, 16'h1005, 16'h0006, 1'b1);

    // Run on up to PC=0010
    for (int a = 6; a < 16; a++) begin
      step();
      check($sformatf("run%0d.instr", a), {16'h0, bus.IF_instruction}, 32'(16'h1000 + a));
    end
    check("run.addr", {16'h0, bus.IF_imemAddr}, 32'h0010);

    // One busy cycle -> one bubble, then same PC re-fetched
    bus.IF_memBusy = 1'b1;
    step();
    check_ifid("starve", 16'h0010, 16'h0800, 16'h0010, 1'b0);
    bus.IF_memBusy = 1'b0;
    step();
    check_ifid("refetch", 16'h0011, 16'h1010, 16'h0011, 1'b1);

    // Branch beats simultaneous stall and memBusy
    bus.IF_branchTaken  = 1'b1;
    bus.IF_branchTarget = 16'h0040;
    bus.IF_stall        = 1'b1;
    bus.IF_memBusy      = 1'b1;
    step();
    check_ifid("flush", 16'h0040, 16'h0800, 16'h0011, 1'b0);
    bus.IF_branchTaken = 1'b0;
    bus.IF_stall       = 1'b0;
    bus.IF_memBusy     = 1'b0;
    step();
    check_ifid("target", 16'h0041, 16'h1040, 16'h0041, 1'b1);

`ifdef FETCH_PERF_COUNTERS_EN
    check("cnt.stall",  {16'h0, bus.IF_stallCount},  32'd2);
    check("cnt.flush",  {16'h0, bus.IF_flushCount},  32'd1);
    check("cnt.starve", {16'h0, bus.IF_starveCount}, 32'd1);
`endif

    // Stall with memBusy only holds
    bus.IF_stall   = 1'b1;
    bus.IF_memBusy = 1'b1;
    step();
    check_ifid("stallbusy", 16'h0041, 16'h1040, 16'h0041, 1'b1);
    bus.IF_stall   = 1'b0;
    bus.IF_memBusy = 1'b0;

    // Wrap: jump to FFFF, fetch it, PC wraps to 0000
    bus.IF_branchTaken  = 1'b1;
    bus.IF_branchTarget = 16'hFFFF;
    step();
    bus.IF_branchTaken = 1'b0;
    check("wrap.addr", {16'h0, bus.IF_imemAddr}, 32'hFFFF);
    step();
    check_ifid("wrap", 16'h0000, 16'h0FFF, 16'h0000, 1'b1);

    // Reset during stall + redirect discards everything
    bus.IF_stall        = 1'b1;
    bus.IF_branchTaken  = 1'b1;
    bus.IF_branchTarget = 16'h0777;
    rst = 1'b0;
    step();
    check_ifid("midrst", 16'h0000, 16'h0800, 16'h0000, 1'b0);
`ifdef FETCH_PERF_COUNTERS_EN
    check("midrst.cnt", {bus.IF_stallCount, bus.IF_flushCount} | {16'h0, bus.IF_starveCount}, 32'd0);
`endif
    bus.IF_stall       = 1'b0;
    bus.IF_branchTaken = 1'b0;
    rst = 1'b1;
    step();
    check_ifid("reboot", 16'h0000, 16'h0800, 16'h0000, 1'b0);
    step();
    check_ifid("refirst", 16'h0001, 16'h1000, 16'h0001, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage_ctrl.md
Name: fetch_stage_ctrl

Overview:
Front end of the 16-bit five-stage pipeline. It owns the PC register and the IF/ID pipeline register, and it consumes the stall request from the ID-stage load-use hazard logic, the branch redirect from EX, and the instruction-memory busy flag from MEM. It decides each cycle whether the front end advances, holds, refills with a bubble, or redirects.

Parameters:
PC_WIDTH, 16, width of the PC and of instruction addresses
INSTR_WIDTH, 16, instruction word width
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0800, encoding placed in IF/ID for bubbles and flushes

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low
IF_stall  in  1  high = load-use hazard in ID; hold PC and IF/ID
IF_branchTaken  in  1  high = EX resolved a taken branch or jump
IF_branchTarget  in  PC_WIDTH  redirect address, valid when IF_branchTaken=1
IF_memBusy  in  1  high = MEM stage owns the shared instruction/data RAM this cycle
IF_imemData  in  INSTR_WIDTH  instruction read data, combinational from IF_imemAddr
IF_imemAddr  out  PC_WIDTH  fetch address, equal to PC register
IF_instruction  out  INSTR_WIDTH  IF/ID instruction
IF_pcPlus1  out  PC_WIDTH  IF/ID PC+1 of the latched instruction
IF_valid  out  1  IF/ID holds a real fetched instruction

Behaviour:
- Reset (rst=0 at a rising edge): PC=RESET_PC, IF_instruction=NOP_INSTR, IF_pcPlus1=0, IF_valid=0, state=BOOT. Reset overrides every other input. Reset asserted mid-stall or mid-redirect discards that activity fully.
- FSM states: BOOT, RUN, HOLD, STARVE, all registered.
- BOOT: lasts exactly one cycle after reset is released. No fetch and no PC update. IF/ID stays NOP. Inputs are ignored. Next state is RUN.
- Per-cycle action in RUN, HOLD or STARVE, by priority, highest first:
  1. IF_branchTaken=1: PC<=IF_branchTarget, IF_instruction<=NOP_INSTR, IF_valid<=0, next=RUN. The flush overrides a simultaneous stall or memBusy.
  2. IF_stall=1: PC and the whole IF/ID register hold, next=HOLD. A stall with memBusy also just holds.
  3. IF_memBusy=1: PC holds, IF_instruction<=NOP_INSTR, IF_valid<=0, next=STARVE.
  4. Otherwise: IF_instruction<=IF_imemData, IF_pcPlus1<=PC+1, IF_valid<=1, PC<=PC+1, next=RUN.
- Fetch latency: the address is presented in cycle N and the instruction is visible at the IF/ID outputs in cycle N+1.
- HOLD: a new fetch happens on the first cycle with IF_stall=0. The held instruction must not be duplicated or skipped.
- STARVE: the same PC is re-fetched on the first cycle with IF_memBusy=0. Exactly one bubble is emitted per busy cycle.
- PC arithmetic is modulo 2^PC_WIDTH: 16'hFFFF+1 wraps to 16'h0000. No overflow flag.
- IF_imemAddr always equals the PC register. It is never muxed with the branch target in the same cycle.
- Stall inputs are active-high throughout. The high level means "do not advance".

Optional Feature:
FETCH_PERF_COUNTERS_EN: when defined, adds outputs IF_stallCount[15:0], IF_flushCount[15:0] and IF_starveCount[15:0].
- Each counter increments once per cycle in which priority case 2, 1 or 3 respectively is taken.
- Each counter saturates at 16'hFFFF.
- All three clear to 0 on reset.
When the macro is undefined, these ports and registers do not exist and the rest of the behaviour is identical.

Test Plan:
- Reset then BOOT: hold rst=0 for 2 cycles, release -> one BOOT cycle with IF_imemAddr=0000 and IF_valid=0. The next cycle latches mem[0000], and IF_pcPlus1=0001.
- Straight-line fetch: memory returns addr+16'h1000 -> IF_instruction sequence 1000, 1001, 1002 on consecutive cycles, with IF_valid=1.
- Load-use stall: IF_stall=1 for 2 cycles at PC=0005 -> IF_instruction stays 1004 for 2 extra cycles and PC stays 0005. Then 1005 is latched with no skip or duplicate.
- Branch beats stall: IF_branchTaken=1, target=0040, IF_stall=1 in the same cycle -> next cycle PC=0040, IF_instruction=0800, IF_valid=0. The following cycle latches 1040.
- Structural starve: IF_memBusy=1 for 1 cycle at PC=0010 -> one NOP bubble (0800, valid=0). Then 1010 is fetched, and PC=0011 afterwards.
- Wrap and counters: PC=FFFF, no hazards -> next PC=0000 and IF_pcPlus1=0000. With FETCH_PERF_COUNTERS_EN defined, IF_stallCount=2, IF_flushCount=1 and IF_starveCount=1 after the scenarios above.
